// File: rtl/hiscore_ram_arbiter.sv
// Arbitrates the single-port game work RAM between the CPU core and the hiscore
// save/restore engine, sequencing the CPU pause handshake around each session.
module hiscore_ram_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  input  logic          hs_req,
  output logic          hs_gnt,
  input  logic          hs_valid,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  input  logic          hs_we,
  output logic          hs_rvalid,
  output logic [DW-1:0] hs_rdata,
  output logic          pause_req,
  input  logic          cpu_paused,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          timeout_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PAUSE_WAIT = 2'd1,
    S_GRANT      = 2'd2,
    S_RELEASE    = 2'd3
  } state_t;

  localparam int SW = $clog2(SETTLE + 1);

  state_t          state_q, state_d;
  logic            pause_req_q, pause_req_d;
  logic            hs_gnt_q, hs_gnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            armed_q, armed_d;
  logic            idle_hold_q, idle_hold_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [9:0]      tmo_q, tmo_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [DW-1:0]   rdata_hold_q, rdata_hold_d;
  logic            rd_issue;

  // Handshake: hs_req is held for a whole session; hs_gnt says the engine owns
  // the RAM, and while it does each cycle with hs_valid=1 is exactly one access.
  assign rd_issue    = (state_q == S_GRANT) & hs_valid & ~hs_we;

  assign hs_gnt      = hs_gnt_q;
  assign pause_req   = pause_req_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;
  assign cpu_rdata   = ram_rdata;
  assign hs_rvalid   = rd_pipe_q[RD_LAT-1];
  // Returned data follows the RAM on the valid cycle and holds otherwise.
  assign hs_rdata    = hs_rvalid ? ram_rdata : rdata_hold_q;

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we;
    if (state_q == S_GRANT) begin
      ram_addr  = hs_addr;
      ram_wdata = hs_wdata;
      ram_we    = hs_valid & hs_we;
    end
  end

  always_comb begin
    state_d       = state_q;
    pause_req_d   = pause_req_q;
    hs_gnt_d      = hs_gnt_q;
    timeout_err_d = timeout_err_q;
    armed_d       = armed_q;
    idle_hold_d   = 1'b0;
    settle_d      = settle_q;
    tmo_d         = tmo_q;
    rd_pipe_d     = (rd_pipe_q << 1) | RD_LAT'(rd_issue);
    rdata_hold_d  = hs_rvalid ? ram_rdata : rdata_hold_q;

    case (state_q)
      S_IDLE: begin
        settle_d = '0;
        tmo_d    = '0;
        if (!hs_req) begin
          armed_d = 1'b1;
        end else if (armed_q && !idle_hold_q) begin
          state_d     = S_PAUSE_WAIT;
          pause_req_d = 1'b1;
        end
      end
      S_PAUSE_WAIT: begin
        if (!hs_req) begin
          state_d     = S_IDLE;
          pause_req_d = 1'b0;
        end else if (cpu_paused && settle_q == SW'(SETTLE - 1)) begin
          state_d  = S_GRANT;
          hs_gnt_d = 1'b1;
        end else if (tmo_q == 10'(TIMEOUT - 1)) begin
          // A timed-out request stays dead until hs_req has been seen low.
          state_d       = S_IDLE;
          pause_req_d   = 1'b0;
          timeout_err_d = 1'b1;
          armed_d       = 1'b0;
        end else begin
          settle_d = cpu_paused ? settle_q + SW'(1) : '0;
          tmo_d    = tmo_q + 10'd1;
        end
      end
      S_GRANT: begin
        if (!hs_req) begin
          state_d  = S_RELEASE;
          hs_gnt_d = 1'b0;
        end
      end
      S_RELEASE: begin
        // Hold the CPU paused until the last outstanding read has been delivered.
        if (rd_pipe_d == '0) begin
          state_d     = S_IDLE;
          pause_req_d = 1'b0;
          idle_hold_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pause_req_q   <= 1'b0;
      hs_gnt_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      armed_q       <= 1'b1;
      idle_hold_q   <= 1'b0;
      settle_q      <= '0;
      tmo_q         <= '0;
      rd_pipe_q     <= '0;
      rdata_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      pause_req_q   <= pause_req_d;
      hs_gnt_q      <= hs_gnt_d;
      timeout_err_q <= timeout_err_d;
      armed_q       <= armed_d;
      idle_hold_q   <= idle_hold_d;
      settle_q      <= settle_d;
      tmo_q         <= tmo_d;
      rd_pipe_q     <= rd_pipe_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: two instances (RD_LAT=2 and 3) share
// stimulus and one RAM model, each with a read pipeline matching its latency.
module tb_hiscore_ram_arbiter;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        hs_req;
  logic        hs_valid;
  logic [15:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic        hs_we;
  logic        cpu_paused;

  logic [7:0]  cpu_rdata_a, hs_rdata_a, ram_wdata_a, ram_rdata_a;
  logic [15:0] ram_addr_a;
  logic        hs_gnt_a, hs_rvalid_a, pause_req_a, ram_we_a, timeout_err_a;
  logic [1:0]  dbg_state_a;

  logic [7:0]  cpu_rdata_b, hs_rdata_b, ram_wdata_b, ram_rdata_b;
  logic [15:0] ram_addr_b;
  logic        hs_gnt_b, hs_rvalid_b, pause_req_b, ram_we_b, timeout_err_b;
  logic [1:0]  dbg_state_b;

  logic [7:0]  mem [0:65535];
  logic [7:0]  pa1, pa2, pb1, pb2, pb3;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hiscore_ram_arbiter #(.AW(16), .DW(8), .RD_LAT(2), .SETTLE(4), .TIMEOUT(1023)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata_a),
    .hs_req(hs_req), .hs_gnt(hs_gnt_a), .hs_valid(hs_valid), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_rvalid(hs_rvalid_a), .hs_rdata(hs_rdata_a),
    .pause_req(pause_req_a), .cpu_paused(cpu_paused),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_rdata(ram_rdata_a),
    .timeout_err(timeout_err_a), .dbg_state(dbg_state_a)
  );

  hiscore_ram_arbiter #(.AW(16), .DW(8), .RD_LAT(3), .SETTLE(4), .TIMEOUT(1023)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata_b),
    .hs_req(hs_req), .hs_gnt(hs_gnt_b), .hs_valid(hs_valid), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_rvalid(hs_rvalid_b), .hs_rdata(hs_rdata_b),
    .pause_req(pause_req_b), .cpu_paused(cpu_paused),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b),
    .timeout_err(timeout_err_b), .dbg_state(dbg_state_b)
  );

  // RAM model: writes from instance a's port, reads delayed by each instance's latency.
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    pa1 <= mem[ram_addr_a];
    pa2 <= pa1;
    pb1 <= mem[ram_addr_b];
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign ram_rdata_a = pa2;
  assign ram_rdata_b = pb3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    cpu_addr   = 16'h1111;
    cpu_wdata  = 8'h00;
    cpu_we     = 1'b0;
    hs_req     = 1'b0;
    hs_valid   = 1'b0;
    hs_addr    = 16'h0000;
    hs_wdata   = 8'h00;
    hs_we      = 1'b0;
    cpu_paused = 1'b0;
    mem[16'h83ED] = 8'h12;
    mem[16'h83EE] = 8'h34;
    mem[16'h83EF] = 8'h56;
    mem[16'h9000] = 8'h3C;
    mem[16'h8800] = 8'h00;

    // Reset values
    tick(); tick();
    check("rst_gnt", hs_gnt_a, 0);
    check("rst_pause", pause_req_a, 0);
    check("rst_rvalid", hs_rvalid_a, 0);
    check("rst_rdata", hs_rdata_a, 0);
    check("rst_err", timeout_err_a, 0);
    check("rst_state", dbg_state_a, ST_IDLE);
    reset_n = 1'b1;
    tick(); tick();

    // Pause handshake: paused rises 2 cycles after pause_req, grant at cycle 7
    hs_req   = 1'b1;
    hs_valid = 1'b1;
    hs_we    = 1'b1;
    hs_addr  = 16'h8000;
    hs_wdata = 8'h77;
    #1;
    check("pre_ram_we_0", ram_we_a, 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 3) cpu_paused = 1'b1;
      if (c == 7) hs_valid = 1'b0;
      #1;
      check($sformatf("gnt_c%0d", c), hs_gnt_a, (c == 7));
      check($sformatf("ram_we_c%0d", c), ram_we_a, 0);
      check($sformatf("pause_c%0d", c), pause_req_a, 1);
    end
    check("gnt_b_c7", hs_gnt_b, 1);

    // Back-to-back reads
    hs_valid = 1'b1; hs_we = 1'b0; hs_addr = 16'h83ED;
    tick(); check("rd_a_t1", hs_rvalid_a, 0); hs_addr = 16'h83EE;
    tick(); check("rd_a_t2", hs_rvalid_a, 1); check("rd_a_d0", hs_rdata_a, 8'h12);
    hs_addr = 16'h83EF;
    tick(); hs_valid = 1'b0;
    check("rd_a_t3", hs_rvalid_a, 1); check("rd_a_d1", hs_rdata_a, 8'h34);
    check("rd_b_t3", hs_rvalid_b, 1); check("rd_b_d0", hs_rdata_b, 8'h12);
    tick();
    check("rd_a_t4", hs_rvalid_a, 1); check("rd_a_d2", hs_rdata_a, 8'h56);
    check("rd_b_t4", hs_rvalid_b, 1); check("rd_b_d1", hs_rdata_b, 8'h34);
    tick();
    check("rd_a_t5", hs_rvalid_a, 0);
    check("rd_b_t5", hs_rvalid_b, 1); check("rd_b_d2", hs_rdata_b, 8'h56);
    tick();
    check("rd_b_t6", hs_rvalid_b, 0);

    // Write in grant with a competing CPU write
    hs_valid = 1'b1; hs_we = 1'b1; hs_addr = 16'h8800; hs_wdata = 8'hA5;
    cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_wdata = 8'hFF;
    #1;
    check("wr_ram_we", ram_we_a, 1);
    check("wr_ram_addr", ram_addr_a, 16'h8800);
    check("wr_ram_wdata", ram_wdata_a, 8'hA5);
    tick();
    hs_valid = 1'b0; cpu_we = 1'b0;
    check("wr_mem_8800", mem[16'h8800], 8'hA5);
    check("wr_mem_9000", mem[16'h9000], 8'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wr_no_rvalid_%0d", i), hs_rvalid_a | hs_rvalid_b, 0);
    end

    // Drop hs_req on the same cycle as a read
    hs_valid = 1'b1; hs_we = 1'b0; hs_addr = 16'h83EE; hs_req = 1'b0;
    tick(); hs_valid = 1'b0;
    check("drop_gnt_b", hs_gnt_b, 0);
    check("drop_pause_b1", pause_req_b, 1);
    check("drop_state_b", dbg_state_b, ST_RELEASE);
    check("drop_ram_cpu", ram_addr_b, 16'h9000);
    tick();
    check("drop_rv_a", hs_rvalid_a, 1); check("drop_rd_a", hs_rdata_a, 8'h34);
    check("drop_pause_a2", pause_req_a, 1);
    tick();
    check("drop_rv_b", hs_rvalid_b, 1); check("drop_rd_b", hs_rdata_b, 8'h34);
    check("drop_pause_b3", pause_req_b, 1);
    check("drop_pause_a3", pause_req_a, 0);
    check("drop_state_a", dbg_state_a, ST_IDLE);
    tick();
    check("drop_pause_b4", pause_req_b, 0);
    check("drop_state_b4", dbg_state_b, ST_IDLE);
    check("drop_rv_b4", hs_rvalid_b, 0);

    // Timeout with cpu_paused held low
    cpu_paused = 1'b0;
    tick(); tick();
    hs_req = 1'b1;
    for (int c = 1; c <= 1023; c++) tick();
    check("tmo_pause_1023", pause_req_a, 1);
    check("tmo_err_1023", timeout_err_a, 0);
    tick();
    check("tmo_err_1024", timeout_err_a, 1);
    check("tmo_err_b_1024", timeout_err_b, 1);
    check("tmo_pause_1024", pause_req_a, 0);
    check("tmo_state", dbg_state_a, ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tmo_no_rearm_%0d", i), pause_req_a, 0);
    end
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    tick();
    check("rearm_pause", pause_req_a, 1);
    check("err_sticky", timeout_err_a, 1);
    hs_req = 1'b0;
    tick();
    check("abort_pause", pause_req_a, 0);
    check("abort_state", dbg_state_a, ST_IDLE);

    // Reset mid-grant with a read outstanding
    cpu_paused = 1'b1;
    tick();
    hs_req = 1'b1;
    for (int i = 0; i < 20 && !hs_gnt_a; i++) tick();
    check("rst2_gnt_up", hs_gnt_a, 1);
    cpu_addr = 16'h1234;
    hs_valid = 1'b1; hs_we = 1'b0; hs_addr = 16'h83EF;
    tick();
    hs_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("rst2_gnt", hs_gnt_a, 0);
    check("rst2_pause", pause_req_a, 0);
    check("rst2_rvalid", hs_rvalid_a, 0);
    check("rst2_err", timeout_err_a, 0);
    check("rst2_ram_addr", ram_addr_a, 16'h1234);
    check("rst2_state", dbg_state_b, ST_IDLE);
    hs_req = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst2_no_rvalid_%0d", i), hs_rvalid_a | hs_rvalid_b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_arbiter.md
Name: hiscore_ram_arbiter

Overview:
- Shares the single-port game work RAM between the CPU core and the hiscore save/restore engine.
- Sequences the CPU pause handshake: request pause, wait for a stable paused acknowledge, grant the RAM port to the hiscore engine, drain outstanding reads, then release the CPU.
- Sits between the galaga core's hs_* RAM port and the hiscore module, in the clk_sys domain.

Parameters:
- AW, 16: RAM address width.
- DW, 8: RAM data width.
- RD_LAT, 1: RAM read latency in cycles, 1..3.
- SETTLE, 4: consecutive cycles cpu_paused must be high before grant.
- TIMEOUT, 1023: maximum cycles spent in PAUSE_WAIT before abort; the counter is 10 bits.

Ports:
- clk  in  1  system clock (clk_sys)
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  AW  CPU-side RAM address
- cpu_wdata  in  DW  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_rdata  out  DW  RAM read data to CPU; combinational pass-through of ram_rdata
- hs_req  in  1  hiscore engine requests the RAM; held high for the whole session
- hs_gnt  out  1  hiscore engine owns the RAM
- hs_valid  in  1  one access command this cycle; ignored unless hs_gnt=1
- hs_addr  in  AW  hiscore address
- hs_wdata  in  DW  hiscore write data
- hs_we  in  1  1 = write, 0 = read
- hs_rvalid  out  1  hs_rdata is valid this cycle
- hs_rdata  out  DW  read data returned to the hiscore engine
- pause_req  out  1  pause request to the CPU core
- cpu_paused  in  1  pause acknowledge from the CPU core
- ram_addr  out  AW  RAM address, muxed
- ram_wdata  out  DW  RAM write data, muxed
- ram_we  out  1  RAM write enable, muxed
- ram_rdata  in  DW  RAM read data
- timeout_err  out  1  sticky; set when a pause request times out

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state = IDLE.
  - pause_req = 0, hs_gnt = 0, hs_rvalid = 0, hs_rdata = 0, timeout_err = 0.
  - Counters cleared; read pipeline cleared.
- RAM mux (combinational):
  - In IDLE, PAUSE_WAIT and RELEASE, ram_* = cpu_*.
  - In GRANT, ram_addr = hs_addr, ram_wdata = hs_wdata, ram_we = hs_valid & hs_we.
  - In GRANT, cpu_we is ignored and never reaches the RAM.
- States:
  - IDLE: on hs_req=1, go to PAUSE_WAIT and assert pause_req the next cycle. Clear the settle and timeout counters. Entry from RELEASE forces at least 1 IDLE cycle before a new request is accepted.
  - PAUSE_WAIT: pause_req=1. The settle counter increments while cpu_paused=1 and clears when cpu_paused=0. When the settle count reaches SETTLE, go to GRANT; hs_gnt rises on the cycle after the SETTLE-th paused cycle. The timeout counter increments every cycle; reaching TIMEOUT sets timeout_err and goes to IDLE with pause_req=0. Once timed out, a request does not re-arm until hs_req has been seen low. If hs_req=0, go to IDLE with pause_req=0.
  - GRANT: hs_gnt=1, pause_req=1. One access is accepted per cycle with hs_valid=1. On hs_req=0, go to RELEASE and drop hs_gnt. A command presented in the same cycle hs_req falls is still executed.
  - RELEASE: pause_req stays 1 until the read pipeline is empty (at most RD_LAT cycles), then pause_req=0 and go to IDLE.
- Read pipeline:
  - A shift register of depth RD_LAT carries {read-issued, nothing else}.
  - hs_rvalid pulses exactly RD_LAT cycles after a read is issued (hs_valid & ~hs_we in GRANT), and hs_rdata captures ram_rdata on that cycle.
  - Back-to-back reads return back-to-back, one per cycle, in order.
  - Writes produce no hs_rvalid.
- cpu_paused dropping during GRANT (core misbehaving): keep the grant; pause_req remains asserted. No error is raised.
- timeout_err is cleared only by reset.
- Reset mid-GRANT: all outputs return to reset values immediately, the RAM mux returns to the CPU, and in-flight reads are discarded.

Test Plan:
- hs_req=1 with cpu_paused rising 2 cycles after pause_req, SETTLE=4 -> hs_gnt=1 exactly 7 cycles after hs_req; ram_we never asserted from cpu_we before then.
- In GRANT, issue reads at addresses 0x83ED, 0x83EE, 0x83EF back-to-back with RAM contents 0x12/0x34/0x56, RD_LAT=2 -> hs_rvalid high 3 consecutive cycles, starting 2 cycles after the first issue, with data 0x12, 0x34, 0x56.
- Write 0xA5 to 0x8800 in GRANT while cpu_we=1 at 0x9000 -> RAM sees only the write to 0x8800; 0x9000 is unchanged.
- Drop hs_req on the same cycle as a read, RD_LAT=3 -> the read completes with hs_rvalid; pause_req falls 3 cycles later; state returns to IDLE.
- cpu_paused held 0 for the whole request -> timeout_err=1 and pause_req=0 after 1023 cycles; a held hs_req does not re-arm until it toggles low then high.
- reset_n pulsed low mid-GRANT with a read outstanding -> hs_gnt=0, pause_req=0, hs_rvalid=0 asynchronously; the RAM mux is back on the CPU.
